// File: rtl/rs232_pkg.sv
// rs232_pkg: parity mode constants and receiver state encoding shared by the rs232 receiver files
package rs232_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: first-word-fall-through receive FIFO with registered overrun pulse
module rs232_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ready,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, pop, wr;
  assign valid = level != '0;
  assign full = level == (AW+1)'(DEPTH);
  assign pop = valid & ready;
  assign wr = push & (~full | pop);
  // empty FIFO presents zeros so the head fields read 0 out of reset
  assign head = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= wdata;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overrun <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + (AW+1)'(wr) - (AW+1)'(pop);
      overrun <= push & full & ~pop;
    end
endmodule

// File: rtl/rs232_receive_fifo.sv
// rs232_receive_fifo: oversampling RS-232 deserializer with parity/framing checks feeding a FWFT FIFO
module rs232_receive_fifo
  import rs232_pkg::*;
#(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE = 12000000,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         rs232_txd,
  output logic [DATA_BITS-1:0]         data,
  output logic                         frame_error,
  output logic                         parity_error,
  output logic                         valid,
  input  logic                         ready,
  output logic                         overrun,
  output logic [$clog2(FIFO_DEPTH):0]  level
);
  localparam int DIV = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW = $clog2(DIV);
  if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("rs232_receive_fifo: illegal parameter combination");
  end
  rx_state_t state, state_nxt;
  logic [1:0] sync;
  logic rx, rx_d, fall, tick, push, par_err, frm_err, par_bad;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  assign rx = sync[1];
  assign fall = rx_d & ~rx;
  assign tick = cnt == '0;
  assign par_bad = ^shreg ^ rx ^ (PARITY == PARITY_ODD);
  always_comb begin
    state_nxt = state;
    push = 1'b0;
    case (state)
      S_IDLE:      state_nxt = fall ? S_START : S_IDLE;
      S_START:     if (tick) state_nxt = rx ? S_IDLE : S_DATA;
      S_DATA:      if (tick && bit_idx == 4'(DATA_BITS - 1))
                     state_nxt = PARITY != PARITY_NONE ? S_PARITY : S_STOP;
      S_PARITY:    if (tick) state_nxt = S_STOP;
      S_STOP:      if (tick && bit_idx == 4'(STOP_BITS - 1)) begin
                     push = 1'b1;
                     state_nxt = rx ? S_IDLE : S_WAIT_HIGH;
                   end
      S_WAIT_HIGH: state_nxt = rx ? S_IDLE : S_WAIT_HIGH;
      default:     state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= S_IDLE;
      sync <= 2'b11;
      rx_d <= 1'b1;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      state <= state_nxt;
      sync <= {sync[0], rs232_txd};
      rx_d <= rx;
      // first expiry lands mid start bit, later ones one bit period apart
      cnt <= state == S_IDLE ? CW'(HALF) : tick ? CW'(DIV - 1) : cnt - 1'b1;
      bit_idx <= state_nxt != state ? '0 : bit_idx + 4'(tick);
      shreg <= state == S_DATA && tick ? {rx, shreg[DATA_BITS-1:1]} : shreg;
      par_err <= state == S_IDLE ? 1'b0 : state == S_PARITY && tick ? par_bad : par_err;
      frm_err <= state == S_IDLE ? 1'b0 : state == S_STOP && tick ? frm_err | ~rx : frm_err;
    end
  rs232_rx_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push    (push),
    .wdata   ({frm_err | ~rx, par_err, shreg}),
    .ready   (ready),
    .head    ({frame_error, parity_error, data}),
    .valid   (valid),
    .overrun (overrun),
    .level   (level)
  );
endmodule

// File: doc/rs232_receive_fifo.md
RS232_RECEIVE_FIFO -- requirements
Module: rs232_receive_fifo

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, 133000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, 12000000, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, 8, data bits per frame, legal 5..9.
REQ-004 SHALL have parameter PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, 1, stop bits checked, legal 1..2.
REQ-006 SHALL have parameter FIFO_DEPTH, 16, receive FIFO entries, power of two, at least 2.
REQ-007 SHALL have port clock, input, 1, single clock for all logic.
REQ-008 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port rs232_txd, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port data, output, DATA_BITS, head FIFO entry, LSB = first received bit.
REQ-011 SHALL have port frame_error, output, 1, framing flag of the head entry.
REQ-012 SHALL have port parity_error, output, 1, parity flag of the head entry; 0 when PARITY = 0.
REQ-013 SHALL have port valid, output, 1, FIFO not empty.
REQ-014 SHALL have port ready, input, 1, consumer accepts the head entry.
REQ-015 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have port level, output, clog2(FIFO_DEPTH)+1, FIFO occupancy.

Function
REQ-017 SHALL pass rs232_txd through a 2-flop synchronizer that resets to 1.
REQ-018 SHALL use bit period DIV = round(CLOCK_FREQ/BAUD_RATE) clocks and half period HALF = DIV/2 (integer division); DIV less than 4 SHALL be a compile-time error.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-020 IDLE: a synchronized 1-to-0 edge SHALL go to START and load the counter with HALF.
REQ-021 START: at counter expiry, a line sampled 0 SHALL go to DATA, otherwise (glitch) back to IDLE with nothing pushed.
REQ-022 DATA: SHALL sample DATA_BITS bits LSB first, one every DIV clocks, then go to PARITY if PARITY is nonzero, else to STOP.
REQ-023 PARITY: SHALL sample one bit; parity_error SHALL be set when the XOR of data and the parity bit is 0 for odd or 1 for even.
REQ-024 STOP: SHALL sample STOP_BITS bits at DIV spacing; any sampled 0 SHALL set frame_error.
REQ-025 After the last stop sample, SHALL push {frame_error, parity_error, data} in the same cycle, then go to IDLE if the line is 1, else to WAIT_HIGH.
REQ-026 WAIT_HIGH (break or framing fault): SHALL return to IDLE only after the synchronized line reads 1; no edge detection meanwhile.
REQ-027 SHALL make the FIFO first-word-fall-through: data, frame_error and parity_error SHALL present the head entry whenever valid=1.
REQ-028 SHALL pop when valid and ready are both 1; when empty, ready SHALL be ignored.
REQ-029 SHALL accept a push when not full, or when full with a pop in the same cycle; level SHALL be unchanged on a simultaneous push and pop.
REQ-030 A push while full without a pop SHALL be dropped, SHALL assert overrun for exactly one cycle, and SHALL leave FIFO contents unchanged.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range 0..FIFO_DEPTH.
REQ-032 Latency SHALL be: valid rises 1 clock after the push cycle.

Reset
REQ-033 resetn=0 SHALL asynchronously force state IDLE, synchronizer to 1, counters to 0, FIFO empty, level=0, valid=0, overrun=0, and data, frame_error and parity_error to 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL restart only on a new falling edge.

Structure
REQ-035 SHALL place PARITY_NONE, PARITY_ODD, PARITY_EVEN constants and the state encoding in shared package rs232_pkg.
REQ-036 SHALL instantiate the FIFO as one sub-module rs232_rx_fifo (parameters WIDTH, DEPTH); the deserializer SHALL remain in rs232_receive_fifo.

Verification
REQ-037 Defaults (DIV=11), send 0xA5 in 8N1, ready=1 -> exactly one valid beat with data 0xA5 and both error flags 0.
REQ-038 PARITY=2, DATA_BITS=7, send 0x41 with parity bit 1 -> data 0x41, parity_error 1; with parity bit 0 -> parity_error 0.
REQ-039 Stop bit driven 0, then line held low 40 bit times -> one entry with frame_error 1 and no further entries until the line returns high.
REQ-040 Start pulse 3 clocks low -> no push, state returns to IDLE.
REQ-041 FIFO_DEPTH=4, ready=0, send 5 frames -> level 4, one overrun pulse, then with ready=1 the first 4 bytes pop in order.
REQ-042 Assert resetn=0 during data bit 4 -> valid 0, level 0; the next complete frame is received correctly.
